// File: rtl/machine_cycle_sequencer_pkg.sv
// Shared timing constants for the machine-cycle sequencer and the per-opcode microcode blocks.
package machine_cycle_sequencer_pkg;

  localparam int STEPS_DEFAULT  = 4;
  localparam int CYCLES_DEFAULT = 8;

  localparam logic [3:0] STEP_T1 = 4'b0001;
  localparam logic [3:0] STEP_T2 = 4'b0010;
  localparam logic [3:0] STEP_T3 = 4'b0100;
  localparam logic [3:0] STEP_T4 = 4'b1000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/machine_cycle_sequencer_ring.sv
// One-hot ring counter: rotates left when enabled, synchronous load forces bit 0.
module onehot_ring_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Enable,
  input  logic             i_Load,
  output logic [WIDTH-1:0] o_Ring
);

  logic [WIDTH-1:0] ring_q, ring_d;

  always_comb begin
    ring_d = ring_q;
    if (i_Load) begin
      ring_d = {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (i_Enable) begin
      ring_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
    end
  end

  always_ff @(posedge i_Clk) begin
    ring_q <= ring_d;
  end

  assign o_Ring = ring_q;

endmodule

// File: rtl/machine_cycle_sequencer.sv
// T-step / M-cycle sequencer: boot fetch, stalls, HALT/wake and M-cycle overrun detection.
module machine_cycle_sequencer
  import machine_cycle_sequencer_pkg::*;
#(
  parameter int STEPS  = STEPS_DEFAULT,
  parameter int CYCLES = CYCLES_DEFAULT
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Enable,
  input  logic              i_Stall,
  input  logic              i_IR_Fetch,
  input  logic              i_Halt_Req,
  input  logic              i_Wake,
  output logic [STEPS-1:0]  o_Cycle_Step,
  output logic [CYCLES-1:0] o_Cycle_Count,
  output logic              o_Boot_Fetch,
  output logic              o_IR_Load,
  output logic              o_Instr_Done,
  output logic              o_Halted,
  output logic              o_Fault
);

  localparam logic [CYCLES-1:0] COUNT_FIRST = {{(CYCLES-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [CYCLES-1:0] count_q, count_d;
  logic              fetch_latch_q, fetch_latch_d;
  logic              fault_q, fault_d;
  logic              ir_load, instr_done;
  logic              advance, last_step, eff_fetch, ring_load;
  logic [STEPS-1:0]  step;

  assign advance   = i_Enable & ~i_Stall & ~i_Reset;
  assign last_step = step[STEPS-1];
  assign eff_fetch = fetch_latch_q | i_IR_Fetch;
  // Reset reaches the step ring through its load path, which has priority over rotation.
  assign ring_load = i_Reset | (advance & (state_q == ST_HALT));

  onehot_ring_counter #(.WIDTH(STEPS)) u_step_ring (
    .i_Clk    (i_Clk),
    .i_Enable (advance),
    .i_Load   (ring_load),
    .o_Ring   (step)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    fetch_latch_d = fetch_latch_q;
    fault_d       = fault_q;
    ir_load       = 1'b0;
    instr_done    = 1'b0;
    if (advance) begin
      if (last_step) begin
        fetch_latch_d = 1'b0;
      end else if ((state_q == ST_RUN) && i_IR_Fetch) begin
        fetch_latch_d = 1'b1;
      end
      case (state_q)
        ST_BOOT: begin
          count_d = '0;
          if (last_step) begin
            state_d = ST_RUN;
            count_d = COUNT_FIRST;
            ir_load = 1'b1;
          end
        end
        ST_RUN: begin
          if (last_step) begin
            // Fetch wins over halt; a wake arriving with the halt request cancels it.
            if (eff_fetch) begin
              count_d    = COUNT_FIRST;
              ir_load    = 1'b1;
              instr_done = 1'b1;
            end else if (i_Halt_Req && !i_Wake) begin
              state_d = ST_HALT;
            end else if (count_q[CYCLES-1]) begin
              fault_d = 1'b1;
            end else begin
              count_d = {count_q[CYCLES-2:0], 1'b0};
            end
          end
        end
        ST_HALT: begin
          count_d = '0;
          if (i_Wake) begin
            state_d = ST_BOOT;
          end
        end
        default: begin
          state_d = ST_BOOT;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= ST_BOOT;
      count_q       <= '0;
      fetch_latch_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      fetch_latch_q <= fetch_latch_d;
      fault_q       <= fault_d;
    end
  end

  assign o_Cycle_Step  = step;
  assign o_Cycle_Count = count_q;
  assign o_Boot_Fetch  = (state_q == ST_BOOT);
  assign o_Halted      = (state_q == ST_HALT);
  assign o_Fault       = fault_q;
  assign o_IR_Load     = ir_load;
  assign o_Instr_Done  = instr_done;

endmodule

// File: tb/tb_machine_cycle_sequencer.sv
// Bench for machine_cycle_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_machine_cycle_sequencer;

  logic       clk;
  logic       rst, en, stall, irf, halt, wake;
  logic [3:0] o_step;
  logic [7:0] o_count;
  logic       o_boot, o_irl, o_done, o_halted, o_fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode, T-step index 0..3, M-cycle index (-1 = none), fetch seen, fault.
  localparam int MB = 0, MR = 1, MH = 2;
  int m_mode = MB;
  int m_t    = 0;
  int m_m    = -1;
  bit m_seen = 1'b0;
  bit m_fault = 1'b0;

  machine_cycle_sequencer dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Enable      (en),
    .i_Stall       (stall),
    .i_IR_Fetch    (irf),
    .i_Halt_Req    (halt),
    .i_Wake        (wake),
    .o_Cycle_Step  (o_step),
    .o_Cycle_Count (o_count),
    .o_Boot_Fetch  (o_boot),
    .o_IR_Load     (o_irl),
    .o_Instr_Done  (o_done),
    .o_Halted      (o_halted),
    .o_Fault       (o_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [16:0] dut_out();
    return {o_step, o_count, o_boot, o_irl, o_done, o_halted, o_fault};
  endfunction

  function automatic logic [16:0] model_out();
    logic [3:0] s;
    logic [7:0] c;
    logic adv, last, fetch, irl, dn;
    s = 4'b0001 << m_t;
    c = (m_m < 0) ? 8'h00 : (8'h01 << m_m);
    adv   = en && !stall && !rst;
    last  = (m_t == 3);
    fetch = m_seen || irf;
    irl = adv && last && ((m_mode == MB) || ((m_mode == MR) && fetch));
    dn  = adv && last && (m_mode == MR) && fetch;
    return {s, c, (m_mode == MB), irl, dn, (m_mode == MH), m_fault};
  endfunction

  task automatic model_update();
    bit last, fetch;
    last  = (m_t == 3);
    fetch = m_seen || irf;
    if (rst) begin
      m_mode = MB; m_t = 0; m_m = -1; m_seen = 0; m_fault = 0;
    end else if (en && !stall) begin
      if (m_mode == MH) begin
        m_t = 0; m_m = -1;
        if (wake) m_mode = MB;
      end else begin
        m_seen = last ? 1'b0 : (m_seen || ((m_mode == MR) && irf));
        if (last) begin
          if (m_mode == MB) begin
            m_mode = MR; m_m = 0;
          end else if (fetch) begin
            m_m = 0;
          end else if (halt && !wake) begin
            m_mode = MH;
          end else if (m_m == 7) begin
            m_fault = 1;
          end else begin
            m_m = m_m + 1;
          end
        end
        m_t = (m_t + 1) % 4;
      end
    end
  endtask

  task automatic drive(input logic e, input logic s, input logic f, input logic h,
                       input logic w, input logic r);
    en = e; stall = s; irf = f; halt = h; wake = w; rst = r;
    #1;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (dut_out() !== {4'b0001, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state act=%h exp=%h", dut_out(), {4'b0001, 8'h00, 5'b10000});
    end
    n_tests++;
    if (dut_out() !== model_out()) begin
      n_fail++;
      $display("FAIL reset_model act=%h exp=%h", dut_out(), model_out());
    end
  endtask

  task automatic test_boot();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      n_tests++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL boot cyc%0d act=%h exp=%h", i, dut_out(), model_out());
      end
      n_tests++;
      if (o_irl !== (i == 3) || o_step !== (4'b0001 << i) || o_boot !== 1'b1) begin
        n_fail++;
        $display("FAIL boot_step cyc%0d step=%b irl=%b boot=%b", i, o_step, o_irl, o_boot);
      end
      tick();
    end
    n_tests++;
    if (o_count !== 8'h01 || o_boot !== 1'b0 || o_step !== 4'b0001) begin
      n_fail++;
      $display("FAIL boot_exit count=%h boot=%b step=%b exp count=01 boot=0", o_count, o_boot, o_step);
    end
  endtask

  task automatic test_add_hl();
    int dones, done_at;
    dones = 0; done_at = -1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, (i == 4), 0, 0, 0);
      n_tests++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL add_hl cyc%0d act=%h exp=%h", i, dut_out(), model_out());
      end
      if (o_done === 1'b1) begin dones++; done_at = i; end
      tick();
    end
    n_tests++;
    if (dones != 1 || done_at != 7 || o_count !== 8'h01) begin
      n_fail++;
      $display("FAIL add_hl_done count=%0d at=%0d cnt=%h exp 1 at 7 cnt=01", dones, done_at, o_count);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      n_tests++;
      if (dut_out() !== model_out() || o_step !== 4'b0100 || o_count !== 8'h04) begin
        n_fail++;
        $display("FAIL stall cyc%0d act=%h exp=%h", i, dut_out(), model_out());
      end
      tick();
    end
    drive(1, 0, 1, 0, 0, 0);
    n_tests++;
    if (o_step !== 4'b0100) begin
      n_fail++;
      $display("FAIL stall_hold step=%b exp=0100", o_step);
    end
    tick();
    n_tests++;
    if (o_step !== 4'b1000 || o_count !== 8'h04) begin
      n_fail++;
      $display("FAIL stall_release step=%b count=%h exp 1000/04", o_step, o_count);
    end
    drive(1, 0, 0, 0, 0, 0);
    n_tests++;
    if (dut_out() !== model_out() || o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_latch act=%h exp=%h", dut_out(), model_out());
    end
    tick();
  endtask

  task automatic test_halt_wake();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 0, 0);
      n_tests++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL halt cyc%0d act=%h exp=%h", i, dut_out(), model_out());
      end
      tick();
    end
    n_tests++;
    if (o_halted !== 1'b1 || o_step !== 4'b0001) begin
      n_fail++;
      $display("FAIL halt_enter halted=%b step=%b exp 1/0001", o_halted, o_step);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, (i == 1), 0, 0);
      tick();
    end
    n_tests++;
    if (dut_out() !== model_out() || o_count !== 8'h00) begin
      n_fail++;
      $display("FAIL halt_idle act=%h exp=%h", dut_out(), model_out());
    end
    drive(1, 0, 0, 1, 1, 0);
    tick();
    n_tests++;
    if (o_boot !== 1'b1 || o_halted !== 1'b0) begin
      n_fail++;
      $display("FAIL wake boot=%b halted=%b exp 1/0", o_boot, o_halted);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      n_tests++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL refetch cyc%0d act=%h exp=%h", i, dut_out(), model_out());
      end
      tick();
    end
    n_tests++;
    if (o_count !== 8'h01 || o_boot !== 1'b0) begin
      n_fail++;
      $display("FAIL refetch_done count=%h exp=01", o_count);
    end
  endtask

  task automatic test_fault_and_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      n_tests++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL overrun cyc%0d act=%h exp=%h", i, dut_out(), model_out());
      end
      tick();
    end
    n_tests++;
    if (o_fault !== 1'b1 || o_count !== 8'h80) begin
      n_fail++;
      $display("FAIL fault_set fault=%b count=%h exp 1/80", o_fault, o_count);
    end
    for (int i = 0; i < 18; i++) begin
      drive(1, 0, (i < 4), 0, 0, 0);
      tick();
    end
    n_tests++;
    if (o_fault !== 1'b1 || o_count !== 8'h08 || o_step !== 4'b0100) begin
      n_fail++;
      $display("FAIL fault_sticky fault=%b count=%h step=%b exp 1/08/0100", o_fault, o_count, o_step);
    end
    drive(1, 0, 1, 1, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (o_step !== 4'b0001 || o_count !== 8'h00 || o_boot !== 1'b1 || o_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid step=%b count=%h boot=%b fault=%b exp 0001/00/1/0",
               o_step, o_count, o_boot, o_fault);
    end
  endtask

  task automatic test_random();
    logic e, s, f, h, w, r;
    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 9) < 2);
      f = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 9) == 0);
      w = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 79) == 0);
      drive(e, s, f, h, w, r);
      n_tests++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL random cyc%0d act=%h exp=%h", i, dut_out(), model_out());
      end
      tick();
    end
  endtask

  initial begin
    en = 0; stall = 0; irf = 0; halt = 0; wake = 0; rst = 1;
    @(negedge clk);
    test_reset();
    test_boot();
    test_add_hl();
    test_stall();
    test_halt_wake();
    test_fault_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
